// File: rtl/sprite_row_fetcher.sv
//==============================================================================
// Module      : sprite_row_fetcher
// Description : Reader side of the tile sprite ROM. Accepts row requests,
//               drives the ROM address, captures the returned row (optionally
//               mirrored) into a one-row staging register and serializes it
//               MSB first as a valid/ready pixel stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sprite_row_fetcher #(
    parameter int TILE_W     = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_tile,
    input  logic [4:0]            req_row,
    input  logic                  req_flip,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [TILE_W-1:0]     rom_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_out,
    output logic                  pix_last
);

    localparam int                CNT_W    = $clog2(TILE_W);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(TILE_W - 1);

    // Fetch stage
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_flip_q;
    logic                  r_fetch_busy;
    // Staging register
    logic [TILE_W-1:0]     r_stage_reg;
    logic                  r_stage_full;
    // Shifter
    logic [TILE_W-1:0]     r_shift_reg;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_shift_full;

    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_load;
    logic [TILE_W-1:0]     w_rev;
    logic [TILE_W-1:0]     w_fetched;

    // Handshake decode; req_ready looks only at registered state
    assign req_ready = !r_fetch_busy && !r_stage_full;
    assign w_accept  = req_valid && req_ready;
    assign pix_valid = r_shift_full;
    assign pix_out   = r_shift_reg[TILE_W-1];
    assign w_last    = r_shift_full && (r_cnt == C_CNT_MAX);
    assign pix_last  = w_last;
    assign w_xfer    = r_shift_full && pix_ready;
    // Shifter takes the staged row when idle or while handing off its last pixel
    assign w_load    = r_stage_full && (!r_shift_full || (w_xfer && w_last));
    assign rom_addr  = r_rom_addr;

    // Mirror of the ROM word for flipped requests
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < TILE_W; i++) begin
            w_rev[i] = rom_data[TILE_W-1-i];
        end
    end

    assign w_fetched = r_flip_q ? w_rev : rom_data;

    // Fetch stage: latch address on accept, busy for exactly one cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr   <= '0;
            r_flip_q     <= 1'b0;
            r_fetch_busy <= 1'b0;
        end else if (w_accept) begin
            r_rom_addr   <= ADDR_WIDTH'({req_tile, req_row});
            r_flip_q     <= req_flip;
            r_fetch_busy <= 1'b1;
        end else begin
            r_fetch_busy <= 1'b0;
        end
    end

    // Staging register: filled by a completing fetch, drained by a shifter load.
    // A fetch only completes while the stage is empty, so fill wins outright.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stage_reg  <= '0;
            r_stage_full <= 1'b0;
        end else if (r_fetch_busy) begin
            r_stage_reg  <= w_fetched;
            r_stage_full <= 1'b1;
        end else if (w_load) begin
            r_stage_full <= 1'b0;
        end
    end

    // Shifter: reload from stage, otherwise shift out one pixel per transfer
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_shift_reg  <= '0;
            r_cnt        <= '0;
            r_shift_full <= 1'b0;
        end else if (w_load) begin
            r_shift_reg  <= r_stage_reg;
            r_cnt        <= '0;
            r_shift_full <= 1'b1;
        end else if (w_xfer) begin
            r_shift_reg <= r_shift_reg << 1;
            // counter parks at the final index; only a reload restarts it
            if (w_last) begin
                r_shift_full <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_row_fetcher.sv
`default_nettype none

module tb_sprite_row_fetcher;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_tile;
    logic [4:0]  req_row;
    logic        req_flip;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_out;
    logic        pix_last;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    bit q_pix[$];
    bit q_last[$];
    int q_cyc[$];

    typedef struct {
        logic        tile;
        logic [4:0]  row;
        logic        flip;
        logic [5:0]  exp_addr;
        logic [31:0] exp_bits;
    } vec_t;

    vec_t tbl[6];

    sprite_row_fetcher #(.TILE_W(32), .ADDR_WIDTH(6)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tile  (req_tile),
        .req_row   (req_row),
        .req_flip  (req_flip),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_out   (pix_out),
        .pix_last  (pix_last)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_model(input logic [5:0] a);
        case (a)
            6'd0:    return 32'hFFFF_FFFF;
            6'd33:   return 32'h1234_5678;
            6'd34:   return 32'h07F8_1FE0;
            6'd37:   return 32'hF000_0000;
            default: return 32'hC0DE_0000 | {26'd0, a};
        endcase
    endfunction

    always_comb rom_data = rom_model(rom_addr);

    // Record each pixel transfer (valid && ready as seen before the next edge)
    always @(negedge Clk) begin
        if (Reset_n && pix_valid && pix_ready) begin
            q_pix.push_back(pix_out);
            q_last.push_back(pix_last);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        q_pix.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Present a request and wait for it to be taken; acc = edge index of accept
    task automatic send(input logic t, input logic [4:0] r, input logic f, output int acc);
        req_valid = 1'b1;
        req_tile  = t;
        req_row   = r;
        req_flip  = f;
        acc       = -1;
        for (int k = 0; k < 200; k++) begin
            if (req_ready) begin
                tick();
                acc = cyc;
                break;
            end
            tick();
        end
        if (acc < 0) chk("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_pix(input int n, input string nm);
        for (int k = 0; k < 400 && q_pix.size() < n; k++) tick();
        if (q_pix.size() < n) chk(nm, 64'(q_pix.size()), 64'(n));
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int k = 0; k < 50; k++) begin
            if (pix_valid) begin
                c = cyc;
                break;
            end
            tick();
        end
        if (c < 0) chk("pix_valid_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pack_pix(input int base);
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++)
            if (base + i < q_pix.size()) v[31-i] = q_pix[base+i];
        return v;
    endfunction

    function automatic logic [31:0] pack_last(input int base);
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++)
            if (base + i < q_last.size()) v[31-i] = q_last[base+i];
        return v;
    endfunction

    task automatic run_row(input vec_t v);
        int acc;
        int c;
        clear_q();
        pix_ready = 1'b1;
        send(v.tile, v.row, v.flip, acc);
        req_valid = 1'b0;
        chk("row_rom_addr", 64'(rom_addr), 64'(v.exp_addr));
        wait_valid(c);
        chk("row_latency", 64'(c - acc), 64'd2);
        wait_pix(32, "row_pixel_count");
        chk("row_data", 64'(pack_pix(0)), 64'(v.exp_bits));
        chk("row_last_mask", 64'(pack_last(0)), 64'h1);
        if (q_cyc.size() >= 32) chk("row_gap", 64'(q_cyc[31] - q_cyc[0]), 64'd31);
        chk("row_valid_after", 64'(pix_valid), 64'd0);
        tick();
        chk("row_no_extra", 64'(q_pix.size()), 64'd32);
    endtask

    initial begin
        int a1, a2, a3, c, n0, seen;

        tbl[0] = '{1'b0, 5'd0,  1'b0, 6'd0,  32'hFFFF_FFFF};
        tbl[1] = '{1'b1, 5'd5,  1'b0, 6'd37, 32'hF000_0000};
        tbl[2] = '{1'b1, 5'd5,  1'b1, 6'd37, 32'h0000_000F};
        tbl[3] = '{1'b1, 5'd1,  1'b1, 6'd33, 32'h1E6A_2C48};
        tbl[4] = '{1'b0, 5'd31, 1'b0, 6'd31, 32'hC0DE_001F};
        tbl[5] = '{1'b1, 5'd31, 1'b1, 6'd63, 32'hFC00_7B03};

        // Reset held with a request pending
        Reset_n   = 1'b0;
        req_valid = 1'b1;
        req_tile  = 1'b1;
        req_row   = 5'd5;
        req_flip  = 1'b0;
        pix_ready = 1'b1;
        tick(); tick(); tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("rst_rom_addr",  64'(rom_addr),  64'd0);
        chk("rst_pix_out",   64'(pix_out),   64'd0);
        chk("rst_pix_last",  64'(pix_last),  64'd0);
        req_valid = 1'b0;
        Reset_n   = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pix_valid) seen++;
        end
        chk("post_rst_idle_valid", 64'(seen), 64'd0);
        chk("post_rst_rom_addr", 64'(rom_addr), 64'd0);

        // Table of single rows
        for (int i = 0; i < 6; i++) run_row(tbl[i]);

        // Back-to-back rows with zero gap
        clear_q();
        pix_ready = 1'b1;
        fork
            begin
                send(1'b0, 5'd0, 1'b0, a1);
                send(1'b1, 5'd1, 1'b0, a2);
                send(1'b1, 5'd2, 1'b0, a3);
                req_valid = 1'b0;
            end
            wait_pix(96, "b2b_pixel_count");
        join
        chk("b2b_accept2_delay", 64'(a2 - a1), 64'd3);
        chk("b2b_accept3_delay", 64'(a3 - a2), 64'd32);
        chk("b2b_row0", 64'(pack_pix(0)),  64'hFFFF_FFFF);
        chk("b2b_row1", 64'(pack_pix(32)), 64'h1234_5678);
        chk("b2b_row2", 64'(pack_pix(64)), 64'h07F8_1FE0);
        chk("b2b_last0", 64'(pack_last(0)),  64'h1);
        chk("b2b_last1", 64'(pack_last(32)), 64'h1);
        chk("b2b_last2", 64'(pack_last(64)), 64'h1);
        if (q_cyc.size() >= 96) chk("b2b_gap", 64'(q_cyc[95] - q_cyc[0]), 64'd95);
        tick();
        chk("b2b_valid_after", 64'(pix_valid), 64'd0);

        // Backpressure after pixel 10, with a second row arriving during the stall
        clear_q();
        pix_ready = 1'b1;
        send(1'b1, 5'd1, 1'b0, a1);
        req_valid = 1'b0;
        wait_pix(10, "bp_pre_count");
        pix_ready = 1'b0;
        send(1'b0, 5'd0, 1'b0, a2);
        req_valid = 1'b1;
        req_tile  = 1'b1;
        req_row   = 5'd2;
        for (int k = 0; k < 6; k++) begin
            chk("bp_hold_out",   64'(pix_out),   64'd1);
            chk("bp_hold_last",  64'(pix_last),  64'd0);
            chk("bp_hold_valid", 64'(pix_valid), 64'd1);
            if (k > 0) chk("bp_req_ready_low", 64'(req_ready), 64'd0);
            tick();
        end
        chk("bp_stall_count", 64'(q_pix.size()), 64'd10);
        req_valid = 1'b0;
        pix_ready = 1'b1;
        wait_pix(64, "bp_pixel_count");
        chk("bp_row0", 64'(pack_pix(0)),  64'h1234_5678);
        chk("bp_row1", 64'(pack_pix(32)), 64'hFFFF_FFFF);
        chk("bp_last0", 64'(pack_last(0)),  64'h1);
        chk("bp_last1", 64'(pack_last(32)), 64'h1);
        tick();
        chk("bp_total", 64'(q_pix.size()), 64'd64);

        // Reset at pixel 17 with a second row staged
        clear_q();
        pix_ready = 1'b1;
        send(1'b0, 5'd0, 1'b0, a1);
        send(1'b1, 5'd1, 1'b0, a2);
        req_valid = 1'b0;
        wait_pix(17, "mid_pre_count");
        chk("mid_rom_addr_before", 64'(rom_addr), 64'd33);
        Reset_n = 1'b0;
        #1;
        chk("mid_pix_valid", 64'(pix_valid), 64'd0);
        chk("mid_pix_last",  64'(pix_last),  64'd0);
        chk("mid_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rom_addr",  64'(rom_addr),  64'd0);
        tick(); tick();
        Reset_n = 1'b1;
        n0   = q_pix.size();
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pix_valid) seen++;
        end
        chk("mid_idle_valid", 64'(seen), 64'd0);
        chk("mid_idle_count", 64'(q_pix.size()), 64'(n0));
        run_row(tbl[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
